// File: rtl/user_ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : user_ahb_pkg
//  Purpose  : Shared encodings for the user AHB-Lite master: HTRANS and HSIZE
//             values, the master FSM state type and the command alignment
//             check.
//  Revision : 1.0 - initial release
// ============================================================================
package user_ahb_pkg;

  localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] C_HSIZE_BYTE = 3'd0;
  localparam logic [2:0] C_HSIZE_HALF = 3'd1;
  localparam logic [2:0] C_HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ahb_state_e;

  // A command is legal when its size is byte/half/word and the address is
  // naturally aligned for that size.
  function automatic logic is_aligned(input logic [2:0] size,
                                      input logic [1:0] addr_lo);
    logic ok;
    case (size)
      C_HSIZE_BYTE: ok = 1'b1;
      C_HSIZE_HALF: ok = ~addr_lo[0];
      C_HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/user_ahb_lane.sv
`default_nettype none
// ============================================================================
//  Module   : user_ahb_lane
//  Purpose  : Byte-lane handling for the AHB master. Replicates right-justified
//             write data across all lanes of HWDATA and extracts the addressed
//             lane of HRDATA as a right-justified, zero-extended value.
//  Ports    : i_size     - HSIZE of the transfer (byte/half/word)
//             i_addr_lo  - HADDR[1:0] of the transfer
//             i_wdata    - right-justified write data
//             i_hrdata   - raw slave read data
//             o_hwdata   - lane-replicated write data
//             o_rdata    - extracted, zero-extended read data
//  Revision : 1.0 - initial release
// ============================================================================
module user_ahb_lane
  import user_ahb_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hrdata,
  output logic [31:0] o_hwdata,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_hwdata = i_wdata;
    o_rdata  = i_hrdata;
    case (i_size)
      C_HSIZE_BYTE: begin
        o_hwdata = {4{i_wdata[7:0]}};
        o_rdata  = {24'd0, i_hrdata[{i_addr_lo, 3'b000} +: 8]};
      end
      C_HSIZE_HALF: begin
        o_hwdata = {2{i_wdata[15:0]}};
        // addr[0] is always 0 for a legal halfword, only addr[1] picks the lane
        o_rdata  = {16'd0, i_hrdata[{i_addr_lo[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/user_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module   : user_ahb_master
//  Purpose  : AHB-Lite single-master initiator. Turns a valid/ready command
//             stream into non-pipelined single AHB transfers and returns read
//             data / error status on a valid/ready response stream.
//  Ports    : HCLK, HRESETn              - clock, async active-low reset
//             cmd_valid/ready/write/addr/size/wdata - command stream
//             rsp_valid/ready/rdata/err  - response stream
//             HSEL, HADDR, HWDATA, HWRITE, HTRANS, HSIZE, HREADY - AHB outputs
//             HRDATA, HREADYOUT          - AHB slave returns
//  Config   : USER_AHB_MASTER_TIMEOUT_EN - when defined, a data phase stalled
//             for TIMEOUT_CYCLES consecutive wait cycles ends with rsp_err=1.
//  Revision : 1.0 - initial release
// ============================================================================
module user_ahb_master
  import user_ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        HSEL,
  output logic        HWRITE,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HREADYOUT
);

  ahb_state_e  state_q, state_d;
  logic        hsel_q, hsel_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] w_hwdata_rep;
  logic [31:0] w_rdata_ext;
  logic        w_tmo_hit;

  user_ahb_lane u_lane (
    .i_size    (hsize_q),
    .i_addr_lo (haddr_q[1:0]),
    .i_wdata   (wdata_q),
    .i_hrdata  (HRDATA),
    .o_hwdata  (w_hwdata_rep),
    .o_rdata   (w_rdata_ext)
  );

`ifdef USER_AHB_MASTER_TIMEOUT_EN
  localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [C_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The hit fires on the wait cycle that would be the TIMEOUT_CYCLES-th in a
  // row; a completing HREADYOUT in that cycle is handled first in the FSM.
  assign w_tmo_hit = (tmo_cnt_q == C_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_ADDR) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_DATA) && !HREADYOUT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hsel_d      = hsel_q;
    hwrite_d    = hwrite_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    htrans_d    = htrans_q;
    hsize_d     = hsize_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_aligned(cmd_size, cmd_addr[1:0])) begin
            state_d  = ST_ADDR;
            hsel_d   = 1'b1;
            htrans_d = C_HTRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            wdata_d  = cmd_wdata;
          end else begin
            // Rejected commands never reach the bus.
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end
        end
      end
      ST_ADDR: begin
        if (HREADYOUT) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = C_HTRANS_IDLE;
          hwdata_d = w_hwdata_rep;
        end
      end
      ST_DATA: begin
        if (HREADYOUT) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = hwrite_q ? 32'd0 : w_rdata_ext;
        end else if (w_tmo_hit) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hsel_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      haddr_q     <= 32'd0;
      hwdata_q    <= 32'd0;
      htrans_q    <= C_HTRANS_IDLE;
      hsize_q     <= C_HSIZE_BYTE;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsel_q      <= hsel_d;
      hwrite_q    <= hwrite_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      hsize_q     <= hsize_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gated with the reset pin so the command port looks busy while in reset.
  assign cmd_ready = (state_q == ST_IDLE) && HRESETn;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign HSEL   = hsel_q;
  assign HWRITE = hwrite_q;
  assign HADDR  = haddr_q;
  assign HWDATA = hwdata_q;
  assign HTRANS = htrans_q;
  assign HSIZE  = hsize_q;
  assign HREADY = HREADYOUT;

endmodule
`default_nettype wire
